// File: rtl/tx_ethernet_sched.sv
// GMII transmit scheduler: round-robin IP/ARP grant, then preamble, header, payload, pad and IFG.
// Define TX_FCS_EN to append a CRC-32 FCS after the padded payload.
module tx_ethernet_sched #(
    parameter logic [47:0] SRC_MAC     = 48'h02_00_00_00_00_01,
    parameter logic [7:0]  PRE_BYTE    = 8'b10101010,
    parameter logic [7:0]  SFD_BYTE    = 8'b10101011,
    parameter int          MIN_PAYLOAD = 46,
    parameter int          MAX_PAYLOAD = 1500,
    parameter int          IFG_CYCLES  = 12
) (
    input  logic        TX_CLK,
    input  logic        rst_n,
    output logic        TX_EN,
    output logic [7:0]  TXD,
    output logic        TX_ER,
    input  logic        ip_req,
    input  logic [47:0] ip_mac_dst,
    input  logic [7:0]  ip_tdata,
    input  logic        ip_tvalid,
    input  logic        ip_tlast,
    output logic        ip_tready,
    output logic        ip_gnt,
    input  logic        arp_req,
    input  logic [47:0] arp_mac_dst,
    input  logic [7:0]  arp_tdata,
    input  logic        arp_tvalid,
    input  logic        arp_tlast,
    output logic        arp_tready,
    output logic        arp_gnt,
    output logic        tx_done,
    output logic        tx_abort
);
    typedef enum logic [3:0] {
        S_IDLE, S_PRE, S_SFD, S_DST, S_SRC, S_TYPE, S_PAYLOAD, S_PAD, S_FCS, S_IFG
    } state_t;

    localparam logic [10:0] MIN_P    = 11'(MIN_PAYLOAD);
    localparam logic [10:0] MAX_P    = 11'(MAX_PAYLOAD);
    localparam logic [10:0] IFG_LAST = 11'(IFG_CYCLES - 1);
    localparam logic        SEL_IP   = 1'b0;
    localparam logic        SEL_ARP  = 1'b1;
`ifdef TX_FCS_EN
    localparam state_t      S_AFTER  = S_FCS;
`else
    localparam state_t      S_AFTER  = S_IFG;
`endif

    state_t      state, state_n;
    logic [10:0] cnt;
    logic [10:0] pay_cnt;
    logic        sel, last_grant, pick, grant_now;
    logic [47:0] dst_q, dst_sh, src_sh;
    logic [15:0] type_q;
    logic [7:0]  cur_tdata;
    logic        cur_tvalid, cur_tlast;
    logic        pay_rdy, hs, abort_now;

    // Tie goes to whichever source did not win last time.
    assign pick      = (ip_req & arp_req) ? ~last_grant : arp_req;
    assign grant_now = (state == S_IDLE) & (ip_req | arp_req);

    assign cur_tdata  = (sel == SEL_ARP) ? arp_tdata  : ip_tdata;
    assign cur_tvalid = (sel == SEL_ARP) ? arp_tvalid : ip_tvalid;
    assign cur_tlast  = (sel == SEL_ARP) ? arp_tlast  : ip_tlast;

    // Byte MAX_PAYLOAD+1 is refused so the frame can be aborted cleanly.
    assign pay_rdy    = (state == S_PAYLOAD) && (pay_cnt != MAX_P);
    assign ip_tready  = pay_rdy & (sel == SEL_IP);
    assign arp_tready = pay_rdy & (sel == SEL_ARP);
    assign hs         = pay_rdy & cur_tvalid;

    assign dst_sh = dst_q   << {cnt[2:0], 3'b000};
    assign src_sh = SRC_MAC << {cnt[2:0], 3'b000};

`ifdef TX_FCS_EN
    logic [31:0] crc, fcs_sh;

    function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    assign fcs_sh = (~crc) >> {cnt[1:0], 3'b000};

    always_ff @(posedge TX_CLK or negedge rst_n) begin
        if (!rst_n)
            crc <= '1;
        else if (state == S_SFD)
            crc <= '1;
        else if ((state inside {S_DST, S_SRC, S_TYPE, S_PAD}) || hs)
            crc <= crc32_byte(crc, TXD);
    end
`endif

    always_comb begin
        state_n   = state;
        TX_EN     = 1'b0;
        TXD       = 8'h00;
        TX_ER     = 1'b0;
        abort_now = 1'b0;
        case (state)
            S_IDLE: if (ip_req | arp_req) state_n = S_PRE;
            S_PRE: begin
                TX_EN = 1'b1;
                TXD   = PRE_BYTE;
                if (cnt == 11'd6) state_n = S_SFD;
            end
            S_SFD: begin
                TX_EN   = 1'b1;
                TXD     = SFD_BYTE;
                state_n = S_DST;
            end
            S_DST: begin
                TX_EN = 1'b1;
                TXD   = dst_sh[47:40];
                if (cnt == 11'd5) state_n = S_SRC;
            end
            S_SRC: begin
                TX_EN = 1'b1;
                TXD   = src_sh[47:40];
                if (cnt == 11'd5) state_n = S_TYPE;
            end
            S_TYPE: begin
                TX_EN = 1'b1;
                TXD   = cnt[0] ? type_q[7:0] : type_q[15:8];
                if (cnt == 11'd1) state_n = S_PAYLOAD;
            end
            S_PAYLOAD: begin
                TX_EN = 1'b1;
                if (hs) begin
                    TXD = cur_tdata;
                    if (cur_tlast)
                        state_n = (pay_cnt < MIN_P - 11'd1) ? S_PAD : S_AFTER;
                end else begin
                    // Underrun or oversize: flag the byte as errored and drop the frame.
                    TX_ER     = 1'b1;
                    abort_now = 1'b1;
                    state_n   = S_IFG;
                end
            end
            S_PAD: begin
                TX_EN = 1'b1;
                if (pay_cnt == MIN_P - 11'd1) state_n = S_AFTER;
            end
`ifdef TX_FCS_EN
            S_FCS: begin
                TX_EN = 1'b1;
                TXD   = fcs_sh[7:0];
                if (cnt == 11'd3) state_n = S_IFG;
            end
`endif
            S_IFG: if (cnt == IFG_LAST) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge TX_CLK or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            pay_cnt    <= '0;
            sel        <= SEL_IP;
            last_grant <= SEL_ARP;
            dst_q      <= '0;
            type_q     <= '0;
            ip_gnt     <= 1'b0;
            arp_gnt    <= 1'b0;
            tx_done    <= 1'b0;
            tx_abort   <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= (state_n != state) ? 11'd0 : cnt + 11'd1;

            if (!(state inside {S_PAYLOAD, S_PAD}))
                pay_cnt <= '0;
            else if (hs || state == S_PAD)
                pay_cnt <= pay_cnt + 11'd1;

            if (grant_now) begin
                sel        <= pick;
                last_grant <= pick;
                dst_q      <= (pick == SEL_ARP) ? arp_mac_dst : ip_mac_dst;
                type_q     <= (pick == SEL_ARP) ? 16'h0806 : 16'h0800;
                ip_gnt     <= (pick == SEL_IP);
                arp_gnt    <= (pick == SEL_ARP);
            end else if (state_n == S_IFG && state != S_IFG) begin
                ip_gnt  <= 1'b0;
                arp_gnt <= 1'b0;
            end

            tx_done  <= (state_n == S_IFG) && (state != S_IFG) && !abort_now;
            tx_abort <= abort_now;
        end
    end
endmodule

// File: tb/tb_tx_ethernet_sched.sv
// Randomized bench for tx_ethernet_sched: frame-level byte model, round-robin order, aborts, async reset.
`timescale 1ns/1ps
module tb_tx_ethernet_sched;
    localparam logic [47:0] SRC_MAC = 48'h02_00_00_00_00_01;
    localparam logic [7:0]  PRE_B   = 8'hAA;
    localparam logic [7:0]  SFD_B   = 8'hAB;
    localparam int          MIN_PAY = 46;
    localparam int          IFG     = 12;

    logic        TX_CLK = 1'b0, rst_n = 1'b0;
    logic        TX_EN, TX_ER, tx_done, tx_abort;
    logic [7:0]  TXD;
    logic        ip_req = 1'b0, ip_tvalid = 1'b0, ip_tlast = 1'b0, ip_tready, ip_gnt;
    logic [47:0] ip_mac_dst = '0;
    logic [7:0]  ip_tdata = '0;
    logic        arp_req = 1'b0, arp_tvalid = 1'b0, arp_tlast = 1'b0, arp_tready, arp_gnt;
    logic [47:0] arp_mac_dst = '0;
    logic [7:0]  arp_tdata = '0;

    tx_ethernet_sched dut (
        .TX_CLK(TX_CLK), .rst_n(rst_n), .TX_EN(TX_EN), .TXD(TXD), .TX_ER(TX_ER),
        .ip_req(ip_req), .ip_mac_dst(ip_mac_dst), .ip_tdata(ip_tdata), .ip_tvalid(ip_tvalid),
        .ip_tlast(ip_tlast), .ip_tready(ip_tready), .ip_gnt(ip_gnt),
        .arp_req(arp_req), .arp_mac_dst(arp_mac_dst), .arp_tdata(arp_tdata), .arp_tvalid(arp_tvalid),
        .arp_tlast(arp_tlast), .arp_tready(arp_tready), .arp_gnt(arp_gnt),
        .tx_done(tx_done), .tx_abort(tx_abort)
    );

    always #5 TX_CLK = ~TX_CLK;

    int nchk = 0, nerr = 0;

    task automatic chk(input string tag, input int got, input int exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Source-side payload queues: {tlast, byte}
    logic [8:0] ip_q[$], arp_q[$];
    logic [7:0] ip_pay[$], arp_pay[$];
    logic [47:0] ip_dst_m, arp_dst_m;
    int  ip_acc = 0, arp_acc = 0, ip_drop = -1;
    logic ip_hs = 1'b0, arp_hs = 1'b0;

    // Captured frames and completion pulses
    logic [7:0] fr_bytes[$];
    int fr_len[$], fr_er[$], fr_erpos[$], fr_gap[$], fr_src[$];
    int pul_kind[$], pul_gap[$], pul_gnt[$];
    bit in_frame = 0;
    int cur_len = 0, cur_er = 0, cur_erpos = -1, gap_cnt = 0, stray = 0, er_bad = 0;

    // Drive sources on the falling edge, sample DUT just before the rising edge.
    initial forever begin
        @(negedge TX_CLK);
        if (ip_hs)  begin void'(ip_q.pop_front());  ip_acc++;  end
        if (arp_hs) begin void'(arp_q.pop_front()); arp_acc++; end
        if (ip_gnt)  ip_req = 1'b0;
        if (arp_gnt) arp_req = 1'b0;
        if (ip_drop >= 0 && ip_acc == ip_drop) begin ip_q.delete(); ip_drop = -1; end
        ip_tvalid  = ip_q.size() > 0;
        ip_tdata   = ip_tvalid ? ip_q[0][7:0] : 8'h00;
        ip_tlast   = ip_tvalid ? ip_q[0][8] : 1'b0;
        arp_tvalid = arp_q.size() > 0;
        arp_tdata  = arp_tvalid ? arp_q[0][7:0] : 8'h00;
        arp_tlast  = arp_tvalid ? arp_q[0][8] : 1'b0;
        #4;
        ip_hs  = ip_tvalid & ip_tready;
        arp_hs = arp_tvalid & arp_tready;
        if (TX_EN) begin
            if (!in_frame) begin
                in_frame = 1; cur_len = 0; cur_er = 0; cur_erpos = -1;
                fr_gap.push_back(gap_cnt);
                fr_src.push_back(ip_gnt ? 0 : (arp_gnt ? 1 : 2));
            end
            fr_bytes.push_back(TXD);
            cur_len++;
            if (TX_ER) begin cur_er++; cur_erpos = cur_len; if (TXD != 8'h00) er_bad++; end
        end else begin
            if (in_frame) begin
                in_frame = 0;
                fr_len.push_back(cur_len); fr_er.push_back(cur_er); fr_erpos.push_back(cur_erpos);
                gap_cnt = 0;
            end
            gap_cnt++;
            if (TX_ER) stray++;
        end
        if (tx_done || tx_abort) begin
            pul_kind.push_back(int'({tx_abort, tx_done}));
            pul_gap.push_back(gap_cnt);
            pul_gnt.push_back(int'(ip_gnt | arp_gnt));
        end
        if ((ip_tready && !ip_gnt) || (arp_tready && !arp_gnt) || (ip_gnt && arp_gnt)) stray++;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n = 1);
        repeat (n) begin @(negedge TX_CLK); #1; end
    endtask

`ifdef TX_FCS_EN
    function automatic logic [31:0] crc_b(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction
`endif

    function automatic int pick_len();
        case ($urandom_range(0, 4))
            0: return 1;
            1: return 45;
            2: return 46;
            3: return 47;
            default: return int'($urandom_range(1, 120));
        endcase
    endfunction

    task automatic load(input bit src, input int n, input bit with_last);
        logic [47:0] d;
        logic [7:0] b;
        d = {16'($urandom), $urandom};
        if (src) begin arp_q.delete(); arp_pay.delete(); arp_acc = 0; arp_dst_m = d; arp_mac_dst = d; end
        else     begin ip_q.delete();  ip_pay.delete();  ip_acc = 0;  ip_dst_m = d;  ip_mac_dst = d;  end
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            if (src) begin arp_q.push_back({with_last && i == n - 1, b}); arp_pay.push_back(b); end
            else     begin ip_q.push_back({with_last && i == n - 1, b});  ip_pay.push_back(b);  end
        end
    endtask

    // Reference model: expected on-wire bytes for one frame
    logic [7:0] exp_q[$];
    int lg = 1;  // most recent winner: 0 IP, 1 ARP

    task automatic build_exp(input bit src, input int nacc, input bit abort);
        logic [47:0] d;
`ifdef TX_FCS_EN
        logic [31:0] c;
`endif
        exp_q.delete();
        repeat (7) exp_q.push_back(PRE_B);
        exp_q.push_back(SFD_B);
        d = src ? arp_dst_m : ip_dst_m;
        for (int i = 5; i >= 0; i--) exp_q.push_back(d[i*8 +: 8]);
        for (int i = 5; i >= 0; i--) exp_q.push_back(SRC_MAC[i*8 +: 8]);
        exp_q.push_back(8'h08);
        exp_q.push_back(src ? 8'h06 : 8'h00);
        for (int i = 0; i < nacc; i++) exp_q.push_back(src ? arp_pay[i] : ip_pay[i]);
        if (abort) exp_q.push_back(8'h00);
        else begin
            for (int i = nacc; i < MIN_PAY; i++) exp_q.push_back(8'h00);
`ifdef TX_FCS_EN
            c = 32'hFFFFFFFF;
            for (int i = 8; i < exp_q.size(); i++) c = crc_b(c, exp_q[i]);
            c = ~c;
            for (int i = 0; i < 4; i++) exp_q.push_back(c[i*8 +: 8]);
`endif
        end
    endtask

    task automatic wait_pulses(input string tag, input int n);
        int t = 0;
        while (pul_kind.size() < n && t < 4000) begin tick(); t++; end
        chk({tag, " completion"}, int'(pul_kind.size() >= n), 1);
    endtask

    task automatic check_frame(input string tag, input bit src, input int nacc, input bit abort, input int gap_exp);
        int len, bad;
        logic [7:0] b;
`ifdef TX_FCS_EN
        logic [31:0] c = 32'hFFFFFFFF;
`endif
        if (fr_len.size() == 0 || pul_kind.size() == 0) begin
            chk({tag, " frame present"}, 0, 1);
            return;
        end
        build_exp(src, nacc, abort);
        len = fr_len.pop_front();
        chk({tag, " len"}, len, exp_q.size());
        bad = 0;
        for (int i = 0; i < len; i++) begin
            b = fr_bytes.pop_front();
`ifdef TX_FCS_EN
            if (i >= 8) c = crc_b(c, b);
`endif
            if (i >= exp_q.size() || b !== exp_q[i]) bad++;
        end
        chk({tag, " bytes"}, bad, 0);
        chk({tag, " src"}, fr_src.pop_front(), int'(src));
        chk({tag, " er_cycles"}, fr_er.pop_front(), int'(abort));
        if (abort) chk({tag, " er_pos"}, fr_erpos.pop_front(), len);
        else void'(fr_erpos.pop_front());
        if (gap_exp > 0) chk({tag, " gap"}, fr_gap.pop_front(), gap_exp);
        else void'(fr_gap.pop_front());
        chk({tag, " pulse"}, pul_kind.pop_front(), abort ? 2 : 1);
        chk({tag, " pulse_cycle"}, pul_gap.pop_front(), 1);
        chk({tag, " gnt_drop"}, pul_gnt.pop_front(), 0);
`ifdef TX_FCS_EN
        if (!abort) chk({tag, " residue"}, int'(c), int'(32'hDEBB20E3));
`endif
        lg = int'(src);
    endtask

    // pat: 0 IP only, 1 ARP only, 2 both in the same cycle
    task automatic run_pair(input string tag, input int pat);
        int ni, na;
        bit w;
        ni = pick_len();
        na = pick_len();
        if (pat != 1) load(0, ni, 1);
        if (pat != 0) load(1, na, 1);
        ip_req  = (pat != 1);
        arp_req = (pat != 0);
        if (pat == 2) begin
            w = (lg == 0);
            wait_pulses(tag, 2);
            check_frame({tag, " first"}, w, w ? na : ni, 0, -1);
            check_frame({tag, " second"}, !w, w ? ni : na, 0, IFG + 1);
        end else begin
            wait_pulses(tag, 1);
            check_frame(tag, pat == 1, (pat == 1) ? na : ni, 0, -1);
        end
        tick(IFG + 2);
    endtask

    initial begin
        int t;
        // Reset state
        tick(3);
        chk("rst TX_EN", int'(TX_EN), 0);
        chk("rst TXD", int'(TXD), 0);
        chk("rst TX_ER", int'(TX_ER), 0);
        chk("rst gnt", int'({ip_gnt, arp_gnt}), 0);
        chk("rst tready", int'({ip_tready, arp_tready}), 0);
        chk("rst pulses", int'({tx_done, tx_abort}), 0);
        rst_n = 1'b1;
        tick(2);
        chk("idle TX_EN", int'(TX_EN), 0);

        // Simultaneous requests straight out of reset: IP first
        run_pair("tie0", 2);

        // ARP broadcast, 28-byte payload padded to 46
        load(1, 28, 1);
        arp_dst_m = 48'hFF_FF_FF_FF_FF_FF;
        arp_mac_dst = arp_dst_m;
        arp_req = 1'b1;
        wait_pulses("arp28", 1);
        check_frame("arp28", 1, 28, 0, -1);
        tick(IFG + 2);

        for (int k = 0; k < 10; k++) run_pair($sformatf("rnd%0d", k), int'($urandom_range(0, 2)));

        // Underrun at byte 40 of 100; ARP request arrives mid-frame
        load(0, 100, 1);
        ip_drop = 39;
        ip_req = 1'b1;
        t = 0;
        while (!ip_gnt && t < 50) begin tick(); t++; end
        load(1, pick_len(), 1);
        arp_req = 1'b1;
        wait_pulses("underrun", 2);
        check_frame("underrun", 0, 39, 1, -1);
        check_frame("after_underrun", 1, arp_pay.size(), 0, IFG + 1);
        tick(IFG + 2);

        // Oversize: 1501 bytes without tlast
        load(0, 1501, 0);
        ip_req = 1'b1;
        wait_pulses("oversize", 1);
        check_frame("oversize", 0, 1500, 1, -1);
        chk("oversize refused", ip_q.size(), 1);
        ip_q.delete();
        tick(IFG + 2);

        // Asynchronous reset in the middle of the payload
        load(0, 60, 1);
        ip_req = 1'b1;
        t = 0;
        while (ip_acc < 10 && t < 100) begin tick(); t++; end
        chk("mid TX_EN before", int'(TX_EN), 1);
        rst_n = 1'b0;
        #1;
        chk("async TX_EN", int'(TX_EN), 0);
        chk("async TX_ER", int'(TX_ER), 0);
        chk("async tready", int'(ip_tready), 0);
        chk("async gnt", int'(ip_gnt), 0);
        tick(2);
        rst_n = 1'b1;
        ip_q.delete(); arp_q.delete(); ip_req = 1'b0; arp_req = 1'b0;
        tick(2);
        fr_bytes.delete(); fr_len.delete(); fr_er.delete(); fr_erpos.delete();
        fr_gap.delete(); fr_src.delete(); pul_kind.delete(); pul_gap.delete(); pul_gnt.delete();
        lg = 1;
        run_pair("tie_after_rst", 2);

        chk("stray outputs", stray, 0);
        chk("er data", er_bad, 0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule

// File: doc/tx_ethernet_sched.md
Name: tx_ethernet_sched

Overview:
Transmit-side frame scheduler for the GMII MAC. Arbitrates round-robin between the IP and ARP next-layer sources and grants the shared GMII transmit interface to one of them. For the granted source it sequences preamble, SFD, destination MAC, source MAC, EtherType, payload, zero padding and the inter-frame gap. It is the TX counterpart of the receive block and uses the same preamble and SFD byte constants.

Parameters:
SRC_MAC, 48'h02_00_00_00_00_01, station MAC inserted as source address
PRE_BYTE, 8'b10101010, preamble byte (7 sent)
SFD_BYTE, 8'b10101011, start-frame delimiter byte
MIN_PAYLOAD, 46, payload bytes below this are zero-padded
MAX_PAYLOAD, 1500, payload byte limit; exceeding it aborts the frame
IFG_CYCLES, 12, idle cycles after every frame

Ports:
TX_CLK  in  1  transmit clock; all logic on its rising edge
rst_n  in  1  reset, asynchronous, active-low
TX_EN  out  1  GMII transmit enable
TXD  out  8  GMII transmit data
TX_ER  out  1  GMII transmit error
ip_req  in  1  IP source requests a frame; held until ip_gnt
ip_mac_dst  in  48  IP destination MAC; sampled on grant
ip_tdata  in  8  IP payload byte
ip_tvalid  in  1  ip_tdata valid
ip_tlast  in  1  marks the last payload byte
ip_tready  out  1  payload byte accepted when ip_tvalid & ip_tready
ip_gnt  out  1  high while the IP frame is owned (grant through IFG start)
arp_req, arp_mac_dst, arp_tdata, arp_tvalid, arp_tlast, arp_tready, arp_gnt  same as the ip_* ports, for the ARP source
tx_done  out  1  one-cycle pulse when a frame completes normally
tx_abort  out  1  one-cycle pulse when a frame is aborted

Behaviour:
- Reset (async assert, sync release): state=IDLE; all outputs 0; last_grant=ARP, so IP wins the first tie.
- States: IDLE -> PRE(7) -> SFD(1) -> DST(6) -> SRC(6) -> TYPE(2) -> PAYLOAD -> PAD -> [FCS(4)] -> IFG(IFG_CYCLES) -> IDLE.
- IDLE: if either request is high, grant in the same cycle and latch mac_dst and EtherType (IP 16'h0800, ARP 16'h0806).
  - Both requests high: grant the source that is not last_grant.
  - last_grant is updated on every grant.
  - The first preamble byte appears on TXD with TX_EN=1 the next cycle.
- Requests are sampled only in IDLE. A request arriving mid-frame waits until after IFG.
- Field order:
  - MACs sent MSB byte first (dst[47:40] first).
  - EtherType sent high byte first.
  - TX_EN=1 from PRE through the last byte before IFG.
- PAYLOAD:
  - tready=1 only for the granted source; the other source's tready=0.
  - TXD is driven from tdata in the same cycle as the handshake (combinational tready, registered TXD one cycle later is not allowed).
  - 11-bit payload counter increments per accepted byte.
  - Accepted byte with tlast: go to PAD if count<MIN_PAYLOAD, otherwise to FCS/IFG.
- Underrun (tvalid=0 in PAYLOAD):
  - TX_EN=1, TX_ER=1, TXD=8'h00 for one cycle.
  - tx_abort pulses, then go to IFG.
  - The source must drop the rest of its frame.
- Oversize (byte MAX_PAYLOAD+1 presented without a prior tlast): same abort sequence; that byte is not accepted.
- PAD: send 8'h00 until total payload+pad = MIN_PAYLOAD.
- IFG:
  - TX_EN=0, TXD=0, gnt deasserts on entry.
  - tx_done pulses on the first IFG cycle for a normal completion.
  - Count IFG_CYCLES, then go to IDLE.
- Frame length: minimum TX_EN-high length is 68 cycles (72 with FCS). Back-to-back frames are separated by exactly IFG_CYCLES idle cycles plus 1 IDLE cycle.
- TX_ER=0 at all times except the abort cycle.

Optional Feature:
TX_FCS_EN
- Defined:
  - CRC-32 (reflected poly 32'hEDB88320, init 32'hFFFFFFFF) is computed over DST..PAD.
  - Its complement is sent in the FCS state, least-significant byte first.
  - The CRC register is cleared in SFD.
  - An aborted frame sends no FCS.
- Undefined: FCS state and CRC logic are absent; PAD/PAYLOAD goes directly to IFG, and FCS is appended downstream.

Test Plan:
- ARP req, mac_dst 48'hFF_FF_FF_FF_FF_FF, 28-byte payload:
  - 7x PRE_BYTE, SFD_BYTE, 6x 8'hFF, SRC_MAC, 08 06, 28 bytes, 18x 8'h00.
  - TX_EN high 68 cycles (72 with TX_FCS_EN), then tx_done and 12 idle cycles.
- ip_req and arp_req high in the same cycle after reset: IP frame is granted first. ARP follows after IFG; TX_EN low for exactly 13 cycles between frames.
- IP 100-byte payload with ip_tvalid dropped at byte 40:
  - TX_ER=1 for one cycle, then tx_abort pulses.
  - No pad and no FCS are sent.
  - arp_req is then serviced normally.
- IP 1501 bytes without tlast: byte 1501 is not accepted, the abort sequence runs, and ip_gnt drops.
- With TX_FCS_EN, 46-byte frame: the checker's CRC register over DST..FCS ends at residue 32'hDEBB20E3.
- rst_n asserted mid-PAYLOAD: TX_EN, TX_ER, tready and gnt go to 0 immediately (asynchronously); after release the block is IDLE and the next grant goes to IP.
